// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit
// Description : Instruction-fetch front end. Owns the fetch PC, issues
//               req/gnt requests to instruction memory, tracks in-flight PCs,
//               buffers returned words in a fetch queue and hands them to ID
//               over valid/ready. EX/ID redirects flush the queue and mark
//               all outstanding responses as stale.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 4,
  parameter int unsigned       FQ_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fnb_jump_i,
  input  logic [ADDR_W-1:0] ex_next_pc_i,
  input  logic              id_jtype_jump,
  input  logic [ADDR_W-1:0] id_jtype_pc_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [31:0]       imem_rdata_i,
  output logic              if_valid_o,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [31:0]       if_inst_o,
  input  logic              id_ready_i
);

  localparam int unsigned c_ptr_w = $clog2(FQ_DEPTH);
  localparam int unsigned c_cnt_w = c_ptr_w + 1;
  // One extra bit so queue occupancy plus in-flight count cannot overflow.
  localparam logic [c_cnt_w:0] c_depth = (c_cnt_w+1)'(FQ_DEPTH);

  // Architectural state
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic               req_q, req_d;
  logic [c_cnt_w-1:0] fq_cnt_q, fq_cnt_d;
  logic [c_cnt_w-1:0] inflight_q, inflight_d;
  logic [c_cnt_w-1:0] drop_q, drop_d;

  // PC FIFO: address of every granted request, popped by each response.
  logic [ADDR_W-1:0]  pcf_mem_q [FQ_DEPTH];
  logic [c_ptr_w-1:0] pcf_wr_q, pcf_rd_q;

  // Fetch queue: {pc, inst} pairs waiting for ID.
  logic [ADDR_W-1:0]  fq_pc_q   [FQ_DEPTH];
  logic [31:0]        fq_inst_q [FQ_DEPTH];
  logic [c_ptr_w-1:0] fq_head_q, fq_tail_q;

  // Handshake decode
  logic              w_grant, w_resp, w_discard, w_push, w_pop, w_redirect;
  logic [ADDR_W-1:0] w_target, w_resp_pc;
  logic [c_cnt_w:0]  w_occ;

  assign w_grant    = req_q & imem_gnt_i;
  assign w_resp     = imem_rvalid_i;
  assign w_discard  = w_resp & (drop_q != '0);
  assign w_push     = w_resp & ~w_discard;
  assign w_pop      = (fq_cnt_q != '0) & id_ready_i;
  // EX redirect is older than the ID one, so it wins.
  assign w_redirect = fnb_jump_i | id_jtype_jump;
  assign w_target   = fnb_jump_i ? ex_next_pc_i : id_jtype_pc_i;
  assign w_resp_pc  = pcf_mem_q[pcf_rd_q];

  // Next-state for PC, counters and request credit.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (w_grant) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
    end
    inflight_d = inflight_q + c_cnt_w'(w_grant) - c_cnt_w'(w_resp);
    drop_d     = drop_q - c_cnt_w'(w_discard);
    fq_cnt_d   = fq_cnt_q + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
    if (w_redirect) begin
      fetch_pc_d = w_target;
      fq_cnt_d   = '0;
      // Everything still outstanding, including a grant taken this cycle,
      // belongs to the abandoned path.
      drop_d     = inflight_d;
    end
    // Request is issued only while a queue slot is reserved for its reply.
    w_occ = {1'b0, fq_cnt_d} + {1'b0, inflight_d};
    req_d = (w_occ < c_depth);
  end

  // Control registers and pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      req_q      <= 1'b0;
      fq_cnt_q   <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      pcf_wr_q   <= '0;
      pcf_rd_q   <= '0;
      fq_head_q  <= '0;
      fq_tail_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      fq_cnt_q   <= fq_cnt_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      if (w_grant) pcf_wr_q <= pcf_wr_q + c_ptr_w'(1);
      if (w_resp)  pcf_rd_q <= pcf_rd_q + c_ptr_w'(1);
      if (w_redirect) begin
        fq_head_q <= '0;
        fq_tail_q <= '0;
      end else begin
        if (w_push) fq_tail_q <= fq_tail_q + c_ptr_w'(1);
        if (w_pop)  fq_head_q <= fq_head_q + c_ptr_w'(1);
      end
    end
  end

  // Storage arrays; contents are only meaningful under the pointers/counters.
  always_ff @(posedge clk) begin
    if (w_grant) begin
      pcf_mem_q[pcf_wr_q] <= fetch_pc_q;
    end
    if (w_push && !w_redirect) begin
      fq_pc_q[fq_tail_q]   <= w_resp_pc;
      fq_inst_q[fq_tail_q] <= imem_rdata_i;
    end
  end

  assign imem_req_o  = req_q;
  assign imem_addr_o = fetch_pc_q;
  assign if_valid_o  = (fq_cnt_q != '0);
  // Head fields read as zero whenever the queue is empty.
  assign if_pc_o     = if_valid_o ? fq_pc_q[fq_head_q]   : '0;
  assign if_inst_o   = if_valid_o ? fq_inst_q[fq_head_q] : '0;

`ifndef SYNTHESIS
  // A response without an outstanding grant means the memory broke protocol.
  a_rvalid_credit : assert property (@(posedge clk) disable iff (rst)
    imem_rvalid_i |-> (inflight_q != '0));
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_unit
// Description : Directed scoreboard bench for if_fetch_unit with an in-order
//               variable-latency instruction memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fnb_jump_i, id_jtype_jump;
  logic [31:0] ex_next_pc_i, id_jtype_pc_i;
  logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
  logic [31:0] imem_addr_o, imem_rdata_i;
  logic        if_valid_o, id_ready_i;
  logic [31:0] if_pc_o, if_inst_o;

  // Second instance for the wrapping reset PC
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_pc, w_inst;

  int tests = 0;
  int fails = 0;
  int npops = 0;
  int unsigned mem_lat = 1;

  logic [31:0] exp_q[$];
  logic [31:0] exp_wrap[$];

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk(clk), .rst(rst),
    .fnb_jump_i(fnb_jump_i), .ex_next_pc_i(ex_next_pc_i),
    .id_jtype_jump(id_jtype_jump), .id_jtype_pc_i(id_jtype_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i(imem_rdata_i),
    .if_valid_o(if_valid_o), .if_pc_o(if_pc_o), .if_inst_o(if_inst_o),
    .id_ready_i(id_ready_i)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst(rst),
    .fnb_jump_i(1'b0), .ex_next_pc_i(32'h0),
    .id_jtype_jump(1'b0), .id_jtype_pc_i(32'h0),
    .imem_req_o(w_req), .imem_addr_o(w_addr),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(1'b0),
    .imem_rdata_i(32'h0),
    .if_valid_o(w_valid), .if_pc_o(w_pc), .if_inst_o(w_inst),
    .id_ready_i(1'b1)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h0F0F_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_stream(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  // Waits (bounded) for if_valid_o; k = negedges seen without valid.
  task automatic wait_valid(output int k);
    k = 0;
    forever begin
      @(negedge clk);
      if (if_valid_o) break;
      k++;
      if (k > 30) break;
    end
  endtask

  // In-order memory: responds mem_lat cycles after each grant.
  typedef struct { logic [31:0] addr; int unsigned t; } pend_t;
  pend_t pend[$];
  int unsigned cyc = 0;
  initial begin : mem_model
    logic        g, rv, r;
    logic [31:0] a;
    pend_t       e;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    forever begin
      @(negedge clk);
      g  = imem_req_o && imem_gnt_i;
      a  = imem_addr_o;
      rv = imem_rvalid_i;
      r  = rst;
      @(posedge clk);
      #1;
      cyc++;
      if (r) begin
        pend.delete();
      end else begin
        if (rv && pend.size() > 0) e = pend.pop_front();
        if (g) pend.push_back('{addr: a, t: cyc - 1});
      end
      if (!r && pend.size() > 0 && (cyc - pend[0].t) >= mem_lat) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_word(pend[0].addr);
      end else begin
        imem_rvalid_i = 1'b0;
      end
    end
  end

  // Scoreboard: every accepted head is compared with the next expected PC.
  initial begin : out_monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst && if_valid_o && id_ready_i && !fnb_jump_i && !id_jtype_jump) begin
        npops++;
        if (exp_q.size() == 0) begin
          chk("unexpected_out", if_pc_o, 32'hDEAD_BEEF);
        end else begin
          e = exp_q.pop_front();
          chk("out_pc", if_pc_o, e);
          chk("out_inst", if_inst_o, mem_word(e));
        end
      end
    end
  end

  // Wrap instance: first granted addresses after reset.
  initial begin : wrap_monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst && w_req && imem_gnt_i && exp_wrap.size() > 0) begin
        e = exp_wrap.pop_front();
        chk("wrap_addr", w_addr, e);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int k;
    int n0;
    rst = 1'b1; fnb_jump_i = 1'b0; id_jtype_jump = 1'b0;
    ex_next_pc_i = '0; id_jtype_pc_i = '0; imem_gnt_i = 1'b0; id_ready_i = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_valid", {31'b0, if_valid_o}, 32'd0);
    chk("rst_pc", if_pc_o, 32'h0);
    chk("rst_inst", if_inst_o, 32'h0);
    chk("rst_req", {31'b0, imem_req_o}, 32'd0);
    chk("rst_addr", imem_addr_o, 32'h0);
    chk("rst_wrap_addr", w_addr, 32'hFFFF_FFF8);

    // Streaming from reset with 1-cycle memory, no bubbles
    exp_wrap.push_back(32'hFFFF_FFF8); exp_wrap.push_back(32'hFFFF_FFFC);
    exp_wrap.push_back(32'h0000_0000); exp_wrap.push_back(32'h0000_0004);
    push_stream(32'h0, 64);
    mem_lat = 1; imem_gnt_i = 1'b1; id_ready_i = 1'b1; rst = 1'b0;
    wait_valid(k);
    chk("first_latency", 32'(k), 32'd3);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_bubble", {31'b0, if_valid_o}, 32'd1);
    end

    // Simultaneous redirects: EX wins
    tick();
    fnb_jump_i = 1'b1; ex_next_pc_i = 32'h200;
    id_jtype_jump = 1'b1; id_jtype_pc_i = 32'h300;
    exp_q.delete(); push_stream(32'h200, 64);
    tick();
    fnb_jump_i = 1'b0; id_jtype_jump = 1'b0;
    chk("prio_addr", imem_addr_o, 32'h200);
    chk("prio_flush", {31'b0, if_valid_o}, 32'd0);
    wait_valid(k);
    chk("redirect_latency", 32'(k), 32'd2);
    repeat (5) tick();

    // ID J-type redirect alone
    id_jtype_jump = 1'b1; id_jtype_pc_i = 32'h300;
    exp_q.delete(); push_stream(32'h300, 64);
    tick();
    id_jtype_jump = 1'b0;
    chk("jt_addr", imem_addr_o, 32'h300);
    repeat (6) tick();

    // Backpressure: queue fills, requests stop, then resume in order
    id_ready_i = 1'b0;
    repeat (10) tick();
    chk("full_req", {31'b0, imem_req_o}, 32'd0);
    chk("full_valid", {31'b0, if_valid_o}, 32'd1);
    chk("full_head_pc", if_pc_o, exp_q[0]);
    chk("full_head_inst", if_inst_o, mem_word(exp_q[0]));
    id_ready_i = 1'b1;
    tick();
    chk("resume_req", {31'b0, imem_req_o}, 32'd1);
    repeat (6) tick();

    // Longer memory latency, redirect with responses in flight
    mem_lat = 3;
    repeat (8) tick();
    fnb_jump_i = 1'b1; ex_next_pc_i = 32'h100;
    exp_q.delete(); push_stream(32'h100, 64);
    tick();
    fnb_jump_i = 1'b0;
    chk("fnb_addr", imem_addr_o, 32'h100);
    chk("fnb_flush", {31'b0, if_valid_o}, 32'd0);
    wait_valid(k);
    repeat (12) tick();

    // Reset mid-stream with a full queue
    mem_lat = 1; id_ready_i = 1'b0;
    repeat (10) tick();
    chk("pre_rst_valid", {31'b0, if_valid_o}, 32'd1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_valid", {31'b0, if_valid_o}, 32'd0);
    chk("mid_rst_pc", if_pc_o, 32'h0);
    chk("mid_rst_inst", if_inst_o, 32'h0);
    chk("mid_rst_req", {31'b0, imem_req_o}, 32'd0);
    chk("mid_rst_addr", imem_addr_o, 32'h0);
    tick(); tick();
    push_stream(32'h0, 64);
    n0 = npops;
    rst = 1'b0; id_ready_i = 1'b1;
    repeat (15) tick();
    chk("restart_pops_ge10", {31'b0, (npops - n0) >= 10}, 32'd1);
    chk("wrap_remaining", 32'(exp_wrap.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
